wb_ram_slave: RTL and testbench

Pipelined Wishbone slave with 16-bit data and a 2^MEM_AW × 16-bit word-addressed RAM. It is the responder that `wb_master` targets for memory-style traffic, and sits on the same 16-bit data / 32-bit address bus as the LED slave. It accepts one request per cycle into a 2-entry request queue and answers strictly in order with ack or err. It back-pressures with `wb_stall_o` when the queue is full.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/wb_req_fifo.sv | 65 ++++++
 rtl/wb_ram_slave.sv | 150 +++++++++++++++
 tb/tb_wb_ram_slave.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone bus widths, request record and executor state encoding
// for the 16-bit data / 32-bit address memory-style slave.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 16;
  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_SEL_W  = 2;

  typedef struct packed {
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    IDLE,
    EXEC
  } exec_state_e;

endpackage

// File: rtl/wb_req_fifo.sv
// Two-entry request queue; flush empties it on the next edge, and a push and
// pop on the same edge leave the occupancy unchanged.
module wb_req_fifo
  import wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    flush,
  input  logic    push,
  input  wb_req_t push_req,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);

  wb_req_t    mem_q [2];
  wb_req_t    mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_req;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/wb_ram_slave.sv
// Pipelined Wishbone RAM slave: queues up to two requests and answers them
// strictly in order with a registered ack (in range) or err (out of range).
module wb_ram_slave
  import wb_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] BASE_ADDR = 32'h0000_0100,
  parameter int unsigned          MEM_AW    = 6,
  parameter int unsigned          READ_WAIT = 0
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_reset_i,
  input  logic [WB_DATA_W-1:0] wb_data_i,
  input  logic [WB_ADDR_W-1:0] wb_addr_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_lock_i,
  input  logic [WB_SEL_W-1:0]  wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic [WB_DATA_W-1:0] wb_data_o,
  output logic                 wb_ack_o,
  output logic                 wb_stall_o,
  output logic                 wb_err_o,
  output logic                 wb_rty_o
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam logic [1:0]  RW    = 2'(READ_WAIT);

  wb_req_t              push_req;
  wb_req_t              head;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, flush;
  exec_state_e          state_q, state_d;
  logic [1:0]           wcnt_q, wcnt_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WB_DATA_W-1:0] data_q, data_d;
  logic [WB_DATA_W-1:0] mem_q [DEPTH];
  logic                 ram_we;
  logic [MEM_AW-1:0]    ram_idx;
  logic                 head_in_range;
  logic                 head_done;
  logic                 unused_lock;

  assign unused_lock = wb_lock_i;

  assign push     = wb_cyc_i & wb_stb_i & ~fifo_full;
  assign flush    = ~wb_cyc_i;
  assign push_req = '{we: wb_we_i, sel: wb_sel_i, addr: wb_addr_i, data: wb_data_i};

  wb_req_fifo u_fifo (
    .clk      (wb_clk_i),
    .rst      (wb_reset_i),
    .flush    (flush),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign ram_idx       = head.addr[MEM_AW-1:0];
  assign head_in_range = (head.addr[WB_ADDR_W-1:MEM_AW] == BASE_ADDR[WB_ADDR_W-1:MEM_AW]);
  assign head_done     = head.we | ~head_in_range | (wcnt_q == RW);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pop     = 1'b0;
    ram_we  = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    data_d  = '0;
    unique case (state_q)
      // Entering EXEC on the push edge lets the head retire in the very next cycle.
      IDLE: begin
        wcnt_d = '0;
        if (push || !fifo_empty) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!fifo_empty) begin
          if (head_done) begin
            pop    = 1'b1;
            wcnt_d = '0;
            if (!head_in_range) begin
              err_d = 1'b1;
            end else begin
              ack_d  = 1'b1;
              ram_we = head.we;
              if (!head.we) begin
                data_d = mem_q[ram_idx];
              end
            end
            if (!fifo_full && !push) begin
              state_d = IDLE;
            end
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end else if (!push) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping the cycle abandons all queued work and any response due next.
    if (!wb_cyc_i) begin
      state_d = IDLE;
      wcnt_d  = '0;
      pop     = 1'b0;
      ram_we  = 1'b0;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      data_d  = '0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (ram_we) begin
      if (head.sel[1]) mem_q[ram_idx][15:8] <= head.data[15:8];
      if (head.sel[0]) mem_q[ram_idx][7:0]  <= head.data[7:0];
    end
  end

  assign wb_data_o  = data_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_stall_o = fifo_full;
  assign wb_rty_o   = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Bench for wb_ram_slave: three instances (READ_WAIT 0, 2, 3) compared every
// cycle against a queue-based reference model, plus directed literal checks.
module tb_wb_ram_slave;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int ND = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stb, we, lock;
  logic [1:0]  sel;
  logic [31:0] addr;
  logic [15:0] wdat;
  logic        cyc   [ND];
  logic [15:0] rdat  [ND];
  logic        ack   [ND];
  logic        err   [ND];
  logic        stall [ND];
  logic        rty   [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    wb_ram_slave #(
      .BASE_ADDR (BASE),
      .MEM_AW    (6),
      .READ_WAIT ((g == 0) ? 0 : (g == 1) ? 2 : 3)
    ) u_dut (
      .wb_clk_i   (clk),
      .wb_reset_i (rst),
      .wb_data_i  (wdat),
      .wb_addr_i  (addr),
      .wb_cyc_i   (cyc[g]),
      .wb_lock_i  (lock),
      .wb_sel_i   (sel),
      .wb_stb_i   (stb),
      .wb_we_i    (we),
      .wb_data_o  (rdat[g]),
      .wb_ack_o   (ack[g]),
      .wb_stall_o (stall[g]),
      .wb_err_o   (err[g]),
      .wb_rty_o   (rty[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit        we;
    bit [1:0]  sel;
    bit [31:0] addr;
    bit [15:0] data;
  } req_t;

  req_t      mq   [ND][$];
  bit [15:0] mmem [ND][64];
  int        mdue [ND];
  int        ecyc = 0;
  bit        e_ack [ND];
  bit        e_err [ND];
  bit        e_stall [ND];
  bit [15:0] e_dat [ND];

  function automatic int rw_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 3;
  endfunction

  function automatic bit in_rng(input bit [31:0] a);
    return (a >> 6) == (BASE >> 6);
  endfunction

  // Cycles a request spends at the head of the queue before it retires.
  function automatic int lat(input int d, input req_t r);
    return (!r.we && in_rng(r.addr)) ? rw_of(d) : 0;
  endfunction

  always @(posedge clk) begin
    ecyc++;
    for (int d = 0; d < ND; d++) begin
      bit   acc;
      req_t h, nr;
      int   i;
      e_ack[d] = 0;
      e_err[d] = 0;
      e_dat[d] = 0;
      if (rst === 1'b1 || cyc[d] !== 1'b1) begin
        mq[d].delete();
      end else begin
        acc = (stb === 1'b1) && (mq[d].size() < 2);
        if (mq[d].size() > 0 && mdue[d] == ecyc) begin
          h = mq[d].pop_front();
          if (!in_rng(h.addr)) begin
            e_err[d] = 1;
          end else begin
            e_ack[d] = 1;
            i = int'(h.addr % 64);
            if (h.we) begin
              if (h.sel[1]) mmem[d][i][15:8] = h.data[15:8];
              if (h.sel[0]) mmem[d][i][7:0]  = h.data[7:0];
            end else begin
              e_dat[d] = mmem[d][i];
            end
          end
          if (mq[d].size() > 0) mdue[d] = ecyc + 1 + lat(d, mq[d][0]);
        end
        if (acc) begin
          nr = '{we: we, sel: sel, addr: addr, data: wdat};
          mq[d].push_back(nr);
          if (mq[d].size() == 1) mdue[d] = ecyc + 1 + lat(d, nr);
        end
      end
      e_stall[d] = (mq[d].size() == 2);
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("ack d%0d", d),   32'(ack[d]),   32'(e_ack[d]));
        check($sformatf("err d%0d", d),   32'(err[d]),   32'(e_err[d]));
        check($sformatf("data d%0d", d),  32'(rdat[d]),  32'(e_dat[d]));
        check($sformatf("stall d%0d", d), 32'(stall[d]), 32'(e_stall[d]));
        check($sformatf("rty d%0d", d),   32'(rty[d]),   32'd0);
      end
    end
  end

  // ---------------- directed helpers ----------------
  bit        rq_we  [4];
  bit [1:0]  rq_sel [4];
  bit [31:0] rq_addr[4];
  bit [15:0] rq_dat [4];
  int        rs_cnt;
  int        rs_t   [4];
  bit        rs_err [4];
  bit [15:0] rs_dat [4];
  bit        st_seen[4];

  // Present n requests back to back (holding on stall); record response times
  // counted in edges from the first presentation.
  task automatic burst(input int d, input int n);
    int t;
    int i;
    bit acc;
    t = 0;
    i = 0;
    rs_cnt = 0;
    for (int k = 0; k < 4; k++) st_seen[k] = 0;
    while ((i < n || rs_cnt < n) && t < 80) begin
      acc = 0;
      if (i < n) begin
        stb  = 1'b1;
        we   = rq_we[i];
        sel  = rq_sel[i];
        addr = rq_addr[i];
        wdat = rq_dat[i];
        if (stall[d]) st_seen[i] = 1;
        acc = !stall[d];
      end else begin
        stb = 1'b0;
      end
      @(posedge clk); #1;
      t++;
      if (acc) i++;
      if (ack[d] || err[d]) begin
        if (rs_cnt < 4) begin
          rs_t[rs_cnt]   = t;
          rs_err[rs_cnt] = err[d];
          rs_dat[rs_cnt] = rdat[d];
        end
        rs_cnt++;
      end
    end
    stb = 1'b0;
    check($sformatf("burst_responses d%0d", d), 32'(rs_cnt), 32'(n));
  endtask

  task automatic one(input int d, input bit w, input bit [1:0] s, input bit [31:0] a,
                     input bit [15:0] v);
    rq_we[0] = w; rq_sel[0] = s; rq_addr[0] = a; rq_dat[0] = v;
    burst(d, 1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int nresp;
    rst = 1'b1; stb = 1'b0; we = 1'b0; lock = 1'b0; sel = '0; addr = '0; wdat = '0;
    for (int d = 0; d < ND; d++) cyc[d] = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    check("reset ack", 32'(ack[0]), 32'd0);
    check("reset stall", 32'(stall[1]), 32'd0);
    rst = 1'b0;

    // Fill every word of every instance so later reads are fully defined.
    for (int d = 0; d < ND; d++) cyc[d] = 1'b1;
    for (int i = 0; i < 64; i++) begin
      stb = 1'b1; we = 1'b1; sel = 2'b11; addr = BASE + 32'(i); wdat = 16'($urandom);
      @(posedge clk); #1;
    end
    stb = 1'b0;
    idle(3);
    for (int d = 0; d < ND; d++) cyc[d] = 1'b0;
    idle(1);

    // READ_WAIT = 0: write/read, byte lanes, sel = 00, out-of-range.
    cyc[0] = 1'b1;
    one(0, 1, 2'b11, 32'h105, 16'hBEEF);
    check("wr beef latency", 32'(rs_t[0]), 32'd2);
    check("wr beef is ack", 32'(rs_err[0]), 32'd0);
    one(0, 0, 2'b11, 32'h105, 16'h0);
    check("rd beef latency", 32'(rs_t[0]), 32'd2);
    check("rd beef data", 32'(rs_dat[0]), 32'hBEEF);
    one(0, 1, 2'b01, 32'h105, 16'h1234);
    one(0, 0, 2'b00, 32'h105, 16'h0);
    check("byte lane data", 32'(rs_dat[0]), 32'hBE34);
    one(0, 1, 2'b00, 32'h105, 16'hFFFF);
    check("sel00 latency", 32'(rs_t[0]), 32'd2);
    check("sel00 is ack", 32'(rs_err[0]), 32'd0);
    one(0, 0, 2'b11, 32'h105, 16'h0);
    check("sel00 no change", 32'(rs_dat[0]), 32'hBE34);
    rq_we[0] = 0; rq_sel[0] = 2'b11; rq_addr[0] = 32'h200; rq_dat[0] = 0;
    rq_we[1] = 0; rq_sel[1] = 2'b11; rq_addr[1] = 32'h105; rq_dat[1] = 0;
    burst(0, 2);
    check("oor is err", 32'(rs_err[0]), 32'd1);
    check("oor data", 32'(rs_dat[0]), 32'd0);
    check("oor time", 32'(rs_t[0]), 32'd2);
    check("after oor is ack", 32'(rs_err[1]), 32'd0);
    check("after oor data", 32'(rs_dat[1]), 32'hBE34);
    check("after oor time", 32'(rs_t[1]), 32'd3);
    cyc[0] = 1'b0;
    idle(1);

    // READ_WAIT = 2: write throughput, then back-pressured reads.
    cyc[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rq_we[i] = 1; rq_sel[i] = 2'b11; rq_addr[i] = BASE + 32'(i); rq_dat[i] = 16'hA000 + 16'(i);
    end
    burst(1, 4);
    check("write stream last", 32'(rs_t[3]), 32'd5);
    check("write stream no stall", 32'(st_seen[3]), 32'd0);
    for (int i = 0; i < 4; i++) rq_we[i] = 0;
    burst(1, 4);
    check("bp stall on 2nd", 32'(st_seen[1]), 32'd0);
    check("bp stall on 3rd", 32'(st_seen[2]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp time %0d", i), 32'(rs_t[i]), 32'(4 + 3 * i));
      check($sformatf("bp data %0d", i), 32'(rs_dat[i]), 32'hA000 + 32'(i));
    end

    // Reset while a read is waiting.
    stb = 1'b1; we = 1'b0; sel = 2'b11; addr = 32'h101;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid ack", 32'(ack[1]), 32'd0);
    check("rst mid err", 32'(err[1]), 32'd0);
    check("rst mid data", 32'(rdat[1]), 32'd0);
    check("rst mid stall", 32'(stall[1]), 32'd0);
    one(1, 0, 2'b11, 32'h101, 16'h0);
    check("post rst latency", 32'(rs_t[0]), 32'd4);
    check("post rst data", 32'(rs_dat[0]), 32'hA001);
    cyc[1] = 1'b0;
    idle(1);

    // READ_WAIT = 3: drop the cycle with a read waiting and a write queued.
    cyc[2] = 1'b1;
    one(2, 1, 2'b11, 32'h107, 16'h5555);
    one(2, 1, 2'b11, 32'h108, 16'h1111);
    stb = 1'b1; we = 1'b0; sel = 2'b11; addr = 32'h100;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h107; wdat = 16'hAAAA;
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h108; wdat = 16'h7777;
    check("abort queue full", 32'(stall[2]), 32'd1);
    cyc[2] = 1'b0;
    stb = 1'b0;
    nresp = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (ack[2] || err[2]) nresp++;
    end
    check("abort no response", 32'(nresp), 32'd0);
    cyc[2] = 1'b1;
    one(2, 0, 2'b11, 32'h107, 16'h0);
    check("abort 107 kept", 32'(rs_dat[0]), 32'h5555);
    one(2, 0, 2'b11, 32'h108, 16'h0);
    check("abort 108 kept", 32'(rs_dat[0]), 32'h1111);
    cyc[2] = 1'b0;
    idle(1);

    // Random traffic on all three instances at once.
    for (int c = 0; c < 2000; c++) begin
      int r;
      for (int d = 0; d < ND; d++) cyc[d] = ($urandom_range(0, 99) < 96);
      rst  = ($urandom_range(0, 299) == 0);
      stb  = ($urandom_range(0, 9) < 7);
      we   = $urandom_range(0, 1) == 1;
      sel  = 2'($urandom_range(0, 3));
      wdat = 16'($urandom);
      lock = $urandom_range(0, 1) == 1;
      r = $urandom_range(0, 9);
      if (r < 8)       addr = BASE + 32'($urandom_range(0, 63));
      else if (r == 8) addr = $urandom;
      else             addr = ($urandom_range(0, 1) == 1) ? BASE + 32'd64 : BASE - 32'd1;
      @(posedge clk); #1;
    end
    rst = 1'b0; stb = 1'b0;
    for (int d = 0; d < ND; d++) cyc[d] = 1'b0;
    idle(3);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
